fft8_pipe: RTL
==============

Name: fft8_pipe

Overview:
- Parametrised 8-point radix-2 DIT FFT/IFFT engine with a 3-stage pipeline and per-frame forward/inverse mode select.
- Accepts one full complex frame per cycle in natural order and delivers results in natural order 3 cycles later.
- Per-stage scaling, saturation and a sticky overflow flag are built in.
- Sits between the sample-framing logic and the downstream demapper; it supersedes the fixed-width single-mode butterfly network.

Parameters:
- DW, 9, signed data width of each real/imag sample (input, internal stage registers, output).
- TW, 10, signed twiddle width, format Q1.(TW-2); 0.7071 = round(0.70710678 * 2^(TW-2)) = 181 at default.
- SCALE, 1, 1 = arithmetic shift right by 1 after every stage (total /8); 0 = no scaling.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  frame on in_re/in_im is valid this cycle.
- in_inverse  in  1  0 = forward (W = e^-j2πk/8), 1 = inverse (conjugate twiddles); sampled with in_valid.
- in_re  in  8*DW  x[n] real, n=0 at bits [DW-1:0], two's complement.
- in_im  in  8*DW  x[n] imag, same packing.
- out_valid  out  1  result frame valid.
- out_inverse  out  1  mode the output frame was computed with.
- out_re  out  8*DW  X[k] real, k=0 at LSBs.
- out_im  out  8*DW  X[k] imag.
- ovf  out  1  sticky: some saturation occurred in a valid frame.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, any time): all pipeline data, valid bits, mode bits, outputs and ovf go to 0 immediately; frames in flight are discarded. First valid output after release requires a new in_valid.
- Function: X[k] = S * Σ x[n]·W^(±nk), with S = 2^-3 if SCALE=1, else 1. The sign is − for forward and + for inverse.
- Pipeline: 3 register stages. in_valid at edge t gives out_valid at edge t+3. Throughput is one frame per cycle; back-to-back frames are allowed and there is no backpressure.
- Valid and mode bits shift every cycle. A stage's data registers load only when that stage's incoming valid is 1, otherwise they hold. Outputs therefore hold the last frame while out_valid=0.
- Mode travels with its frame. Frames of different modes may be interleaved cycle by cycle.
- Input bit-reversal is pure wiring ahead of stage 1.
- Stage 1: span-1 butterflies, twiddle 1.
- Stage 2: span-2 butterflies, twiddles 1 and ∓j.
- Stage 3: span-4 butterflies, twiddles W^0..W^3.
- Multiplication by 1 and ±j is exact (swap/negate).
- Multiplication by ±0.7071 products: full-precision multiply, add 2^(TW-3), arithmetic shift right by TW-2 (round half up).
- Butterfly: a' = a + b·w, b' = a − b·w, computed at DW+2 bits.
- If SCALE=1, a' and b' are then arithmetically shifted right by 1 (floor).
- Every component is then saturated to [−2^(DW-1), 2^(DW-1)−1] before being registered.
- ovf: set at any edge where a stage with valid=1 saturates any component. ovf_clr clears it. If clear and a new saturation coincide, ovf = 1.
- Negation of −2^(DW-1), including the ±j path, saturates to 2^(DW-1)−1 and counts as overflow.

Test Plan:
- Impulse, forward, SCALE=1, DW=9: x[0]=64+0j, other x=0, one in_valid pulse → exactly 3 cycles later out_valid=1 for one cycle, all X[k]=8+0j, ovf=0.
- Shifted impulse: x[2]=64, forward → X = {8, −8j, −8, 8j, 8, −8j, −8, 8j}. Same frame with in_inverse=1 → X = {8, 8j, −8, −8j, 8, 8j, −8, −8j}, and out_inverse=1.
- Twiddle rounding: x[1]=64, forward → X[1]=6−6j ±1 LSB against a bit-exact model. The bench checks all 8 bins bit-exact against a reference model implementing the rounding/floor rules above.
- Saturation: SCALE=0 build, all x=255+0j → X[0]=255, others 0, ovf=1 and held. Then ovf_clr for one cycle → ovf=0; ovf_clr coincident with a new saturating frame → ovf stays 1.
- Streaming: 10 consecutive frames, alternating modes, random data → 10 consecutive out_valid cycles in order, each bit-exact, each with matching out_inverse. After a gap, outputs hold the last frame.
- Reset mid-flight: assert rst one cycle after in_valid → outputs, ovf and out_valid are 0 immediately. No out_valid appears after release until new input.

Source files
------------

// File: rtl/fft8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fft8_pipe (with helper fft8_bfly)
// Brief    : 3-stage pipelined 8-point radix-2 DIT FFT/IFFT with per-stage
//            scaling, saturation and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================

module fft8_bfly #(
    parameter int DW    = 9,
    parameter int TW    = 10,
    parameter int SCALE = 1
) (
    input  logic signed [DW-1:0] i_a_re,
    input  logic signed [DW-1:0] i_a_im,
    input  logic signed [DW-1:0] i_b_re,
    input  logic signed [DW-1:0] i_b_im,
    input  logic        [1:0]    i_k,
    input  logic                 i_inv,
    output logic signed [DW-1:0] o_x_re,
    output logic signed [DW-1:0] o_x_im,
    output logic signed [DW-1:0] o_y_re,
    output logic signed [DW-1:0] o_y_im,
    output logic                 o_sat
);
    localparam int c_ww   = DW + 2;
    localparam int c_pw   = DW + TW;
    localparam int c_w707 = int'(0.70710678 * (2.0 ** (TW - 2)));
    localparam logic signed [DW-1:0]   c_min   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [c_ww-1:0] c_max_w = c_ww'((1 << (DW - 1)) - 1);
    localparam logic signed [c_ww-1:0] c_min_w = c_ww'(-(1 << (DW - 1)));

    logic signed [c_pw-1:0] w_pf_re, w_pf_im;
    logic signed [c_ww-1:0] w_p_re, w_p_im, w_neg_re, w_neg_im;
    logic signed [c_ww-1:0] w_t_re, w_t_im;
    logic signed [c_ww-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic                   w_neg_sat;
    logic [3:0]             w_clip;

    // b * 0.7071 with round-half-up; the twiddle signs are applied afterwards
    assign w_pf_re = (c_pw'(i_b_re) * c_pw'(c_w707) + c_pw'(1 << (TW - 3))) >>> (TW - 2);
    assign w_pf_im = (c_pw'(i_b_im) * c_pw'(c_w707) + c_pw'(1 << (TW - 3))) >>> (TW - 2);
    assign w_p_re  = c_ww'(w_pf_re);
    assign w_p_im  = c_ww'(w_pf_im);

    assign w_neg_re = (i_b_re == c_min) ? c_max_w : -c_ww'(i_b_re);
    assign w_neg_im = (i_b_im == c_min) ? c_max_w : -c_ww'(i_b_im);

    always_comb begin
        w_neg_sat = 1'b0;
        w_t_re    = c_ww'(i_b_re);
        w_t_im    = c_ww'(i_b_im);
        case (i_k)
            2'd1: begin
                if (i_inv) begin
                    w_t_re = w_p_re - w_p_im;
                    w_t_im = w_p_re + w_p_im;
                end else begin
                    w_t_re = w_p_re + w_p_im;
                    w_t_im = w_p_im - w_p_re;
                end
            end
            2'd2: begin
                // forward multiplies by -j, inverse by +j
                if (i_inv) begin
                    w_t_re    = w_neg_im;
                    w_t_im    = c_ww'(i_b_re);
                    w_neg_sat = (i_b_im == c_min);
                end else begin
                    w_t_re    = c_ww'(i_b_im);
                    w_t_im    = w_neg_re;
                    w_neg_sat = (i_b_re == c_min);
                end
            end
            2'd3: begin
                if (i_inv) begin
                    w_t_re = -w_p_re - w_p_im;
                    w_t_im = w_p_re - w_p_im;
                end else begin
                    w_t_re = w_p_im - w_p_re;
                    w_t_im = -w_p_re - w_p_im;
                end
            end
            default: ;
        endcase
    end

    assign w_sum_re = c_ww'(i_a_re) + w_t_re;
    assign w_sum_im = c_ww'(i_a_im) + w_t_im;
    assign w_dif_re = c_ww'(i_a_re) - w_t_re;
    assign w_dif_im = c_ww'(i_a_im) - w_t_im;

    function automatic logic [DW:0] clip(input logic signed [c_ww-1:0] v);
        logic signed [c_ww-1:0] s;
        s = (SCALE != 0) ? (v >>> 1) : v;
        if (s > c_max_w)      clip = {1'b1, c_max_w[DW-1:0]};
        else if (s < c_min_w) clip = {1'b1, c_min_w[DW-1:0]};
        else                  clip = {1'b0, s[DW-1:0]};
    endfunction

    assign {w_clip[0], o_x_re} = clip(w_sum_re);
    assign {w_clip[1], o_x_im} = clip(w_sum_im);
    assign {w_clip[2], o_y_re} = clip(w_dif_re);
    assign {w_clip[3], o_y_im} = clip(w_dif_im);
    assign o_sat = w_neg_sat | (|w_clip);
endmodule

module fft8_pipe #(
    parameter int DW    = 9,
    parameter int TW    = 10,
    parameter int SCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_inverse,
    input  logic [8*DW-1:0] in_re,
    input  logic [8*DW-1:0] in_im,
    output logic            out_valid,
    output logic            out_inverse,
    output logic [8*DW-1:0] out_re,
    output logic [8*DW-1:0] out_im,
    output logic            ovf,
    input  logic            ovf_clr
);
    logic [2:0][7:0][DW-1:0] re_q, re_d, im_q, im_d;
    logic [2:0][7:0][DW-1:0] src_re, src_im, bf_re, bf_im;
    logic [7:0][DW-1:0]      br_re, br_im;
    logic [2:0][3:0]         bf_sat;
    logic [2:0]              v_q, v_d, inv_q, inv_d, src_v, src_inv;
    logic                    ovf_q, ovf_d, sat_any;

    // Bit-reversed input ordering is a pure permutation of the input bus
    for (genvar n = 0; n < 8; n++) begin : g_bitrev
        localparam int c_src = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
        assign br_re[n] = in_re[c_src*DW +: DW];
        assign br_im[n] = in_im[c_src*DW +: DW];
    end

    assign src_re  = {re_q[1], re_q[0], br_re};
    assign src_im  = {im_q[1], im_q[0], br_im};
    assign src_v   = {v_q[1:0], in_valid};
    assign src_inv = {inv_q[1:0], in_inverse};

    for (genvar s = 0; s < 3; s++) begin : g_stage
        localparam int c_h = 1 << s;
        for (genvar b = 0; b < 4; b++) begin : g_bfly
            localparam int         c_j = b % c_h;
            localparam int         c_i = (b / c_h) * 2 * c_h + c_j;
            localparam logic [1:0] c_k = 2'(c_j << (2 - s));
            fft8_bfly #(.DW(DW), .TW(TW), .SCALE(SCALE)) u_bfly (
                .i_a_re (src_re[s][c_i]),
                .i_a_im (src_im[s][c_i]),
                .i_b_re (src_re[s][c_i + c_h]),
                .i_b_im (src_im[s][c_i + c_h]),
                .i_k    (c_k),
                .i_inv  (src_inv[s]),
                .o_x_re (bf_re[s][c_i]),
                .o_x_im (bf_im[s][c_i]),
                .o_y_re (bf_re[s][c_i + c_h]),
                .o_y_im (bf_im[s][c_i + c_h]),
                .o_sat  (bf_sat[s][b])
            );
        end
    end

    always_comb begin
        v_d     = src_v;
        inv_d   = src_inv;
        re_d    = re_q;
        im_d    = im_q;
        sat_any = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (src_v[s]) begin
                re_d[s] = bf_re[s];
                im_d[s] = bf_im[s];
            end
            sat_any = sat_any | (src_v[s] & (|bf_sat[s]));
        end
        ovf_d = (ovf_q & ~ovf_clr) | sat_any;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q  <= '0;
            im_q  <= '0;
            v_q   <= '0;
            inv_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            re_q  <= re_d;
            im_q  <= im_d;
            v_q   <= v_d;
            inv_q <= inv_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid   = v_q[2];
    assign out_inverse = inv_q[2];
    assign out_re      = re_q[2];
    assign out_im      = im_q[2];
    assign ovf         = ovf_q;
endmodule

`default_nettype wire
